// File: rtl/lcd_timing_decoder.sv
// Receive-side LCD timing decoder: recovers pixel X/Y, sync totals and geometry lock from HS/VS/DE.
// Optional sticky error status (err_clr/err_status) is built when LCD_TIMING_DEC_STICKY_ERR_EN is defined.
module lcd_timing_decoder #(
  parameter logic [10:0] H_VALID     = 11'd800,
  parameter logic [10:0] V_VALID     = 11'd480,
  parameter logic        HS_POL      = 1'b1,
  parameter logic        VS_POL      = 1'b1,
  parameter logic [3:0]  LOCK_FRAMES = 4'd2
) (
  input  logic        lcd_clk,
  input  logic        sys_rst_n,
  input  logic        lcd_hs,
  input  logic        lcd_vs,
  input  logic        lcd_de,
`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
  input  logic        err_clr,
  output logic [1:0]  err_status,
`endif
  output logic        pix_valid,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        frame_start,
  output logic [11:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic        err_hact,
  output logic        err_vact,
  output logic        locked
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    sat_inc11 = (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    sat_inc12 = (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  logic        hs_a;
  logic        vs_a;
  logic        hs_a_d_reg;
  logic        vs_a_d_reg;
  logic        de_d_reg;
  logic        hs_edge;
  logic        vs_edge;
  logic        de_fall;

  logic [10:0] x_cnt_reg;
  logic [10:0] y_cnt_reg;
  logic [10:0] act_lines_reg;
  logic [10:0] v_cnt_reg;
  logic [11:0] h_cnt_reg;
  logic        first_vs_reg;
  logic        meas_valid_reg;
  logic        frame_dirty_reg;

  logic [10:0] act_lines_next;
  logic        err_hact_next;
  logic        err_vact_next;
  logic        frame_clean;

  lock_state_t state_reg;
  logic [3:0]  good_cnt_reg;
  logic [4:0]  good_inc;

  assign hs_a    = (lcd_hs == HS_POL);
  assign vs_a    = (lcd_vs == VS_POL);
  assign hs_edge = hs_a & ~hs_a_d_reg;
  assign vs_edge = vs_a & ~vs_a_d_reg;
  assign de_fall = ~lcd_de & de_d_reg;

  // A line ending on the VSYNC edge still belongs to the frame being closed.
  assign act_lines_next = de_fall ? sat_inc11(act_lines_reg) : act_lines_reg;

  // Errors are only meaningful once a frame boundary has been seen since reset.
  assign err_hact_next  = de_fall & first_vs_reg & (x_cnt_reg != H_VALID);
  assign err_vact_next  = vs_edge & first_vs_reg & (act_lines_next != V_VALID);

  // The first full frame has no earlier full-frame total to compare against.
  assign frame_clean = first_vs_reg & ~frame_dirty_reg & ~err_hact_next
                     & (act_lines_next == V_VALID)
                     & (~meas_valid_reg | (v_cnt_reg == v_total_meas));

  assign good_inc = {1'b0, good_cnt_reg} + 5'd1;

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_a_d_reg <= 1'b0;
      vs_a_d_reg <= 1'b0;
      de_d_reg   <= 1'b0;
    end else begin
      hs_a_d_reg <= hs_a;
      vs_a_d_reg <= vs_a;
      de_d_reg   <= lcd_de;
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_valid  <= 1'b0;
      pixel_xpos <= 11'd0;
      pixel_ypos <= 11'd0;
      x_cnt_reg  <= 11'd0;
    end else if (lcd_de) begin
      pix_valid  <= 1'b1;
      pixel_xpos <= hs_edge ? 11'd0 : x_cnt_reg;
      pixel_ypos <= y_cnt_reg;
      x_cnt_reg  <= hs_edge ? 11'd1 : sat_inc11(x_cnt_reg);
    end else begin
      pix_valid <= 1'b0;
      if (de_fall || hs_edge) begin
        x_cnt_reg <= 11'd0;
      end
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      y_cnt_reg     <= 11'd0;
      act_lines_reg <= 11'd0;
    end else if (vs_edge) begin
      y_cnt_reg     <= 11'd0;
      act_lines_reg <= 11'd0;
    end else if (de_fall) begin
      y_cnt_reg     <= sat_inc11(y_cnt_reg);
      act_lines_reg <= sat_inc11(act_lines_reg);
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_reg    <= 12'd0;
      h_total_meas <= 12'd0;
    end else if (hs_edge) begin
      h_total_meas <= sat_inc12(h_cnt_reg);
      h_cnt_reg    <= 12'd0;
    end else begin
      h_cnt_reg <= sat_inc12(h_cnt_reg);
    end
  end

  // An HSYNC coinciding with VSYNC is the first line of the new frame.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v_cnt_reg    <= 11'd0;
      v_total_meas <= 11'd0;
    end else if (vs_edge) begin
      v_total_meas <= v_cnt_reg;
      v_cnt_reg    <= hs_edge ? 11'd1 : 11'd0;
    end else if (hs_edge) begin
      v_cnt_reg <= sat_inc11(v_cnt_reg);
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start     <= 1'b0;
      err_hact        <= 1'b0;
      err_vact        <= 1'b0;
      first_vs_reg    <= 1'b0;
      meas_valid_reg  <= 1'b0;
      frame_dirty_reg <= 1'b0;
    end else begin
      frame_start     <= vs_edge;
      err_hact        <= err_hact_next;
      err_vact        <= err_vact_next;
      first_vs_reg    <= first_vs_reg | vs_edge;
      meas_valid_reg  <= meas_valid_reg | (vs_edge & first_vs_reg);
      frame_dirty_reg <= vs_edge ? 1'b0 : (frame_dirty_reg | err_hact_next);
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= ST_HUNT;
      good_cnt_reg <= 4'd0;
      locked       <= 1'b0;
    end else if (vs_edge) begin
      case (state_reg)
        ST_HUNT: begin
          if (frame_clean) begin
            good_cnt_reg <= 4'd1;
            if (LOCK_FRAMES <= 4'd1) begin
              state_reg <= ST_LOCKED;
              locked    <= 1'b1;
            end else begin
              state_reg <= ST_COUNT;
              locked    <= 1'b0;
            end
          end else begin
            good_cnt_reg <= 4'd0;
            locked       <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (frame_clean) begin
            good_cnt_reg <= good_inc[3:0];
            if (good_inc >= {1'b0, LOCK_FRAMES}) begin
              state_reg <= ST_LOCKED;
              locked    <= 1'b1;
            end
          end else begin
            state_reg    <= ST_HUNT;
            good_cnt_reg <= 4'd0;
            locked       <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (!frame_clean) begin
            state_reg    <= ST_HUNT;
            good_cnt_reg <= 4'd0;
            locked       <= 1'b0;
          end
        end
        default: begin
          state_reg    <= ST_HUNT;
          good_cnt_reg <= 4'd0;
          locked       <= 1'b0;
        end
      endcase
    end
  end

`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
  // A new pulse takes priority over a clear arriving in the same cycle.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_status <= 2'b00;
    end else begin
      err_status[0] <= err_hact | (err_status[0] & ~err_clr);
      err_status[1] <= err_vact | (err_status[1] & ~err_clr);
    end
  end
`endif

endmodule

// File: tb/tb_lcd_timing_decoder.sv
// Bench for lcd_timing_decoder: one positive-polarity and one negative-polarity instance share a
// randomized 12 clk x 8 line stream and are checked against a frame-level reference model.
module tb_lcd_timing_decoder;

  localparam int HV    = 8;
  localparam int VV    = 4;
  localparam int LINE  = 12;
  localparam int LINES = 8;
  localparam int LOCKN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, hs, vs, de;
  logic hs_n, vs_n;
  assign hs_n = ~hs;
  assign vs_n = ~vs;

  logic        pv_p, pv_n, fs_p, fs_n, eh_p, eh_n, ev_p, ev_n, lk_p, lk_n;
  logic [10:0] xp_p, xp_n, yp_p, yp_n, vt_p, vt_n;
  logic [11:0] ht_p, ht_n;
`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
  logic        err_clr;
  logic [1:0]  st_p, st_n;
  logic [1:0]  exp_status, prev_pulse;
`endif

  lcd_timing_decoder #(.H_VALID(11'd8), .V_VALID(11'd4), .HS_POL(1'b1), .VS_POL(1'b1),
                       .LOCK_FRAMES(4'd2)) dut_p (
    .lcd_clk(clk), .sys_rst_n(rst_n), .lcd_hs(hs), .lcd_vs(vs), .lcd_de(de),
`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
    .err_clr(err_clr), .err_status(st_p),
`endif
    .pix_valid(pv_p), .pixel_xpos(xp_p), .pixel_ypos(yp_p), .frame_start(fs_p),
    .h_total_meas(ht_p), .v_total_meas(vt_p), .err_hact(eh_p), .err_vact(ev_p), .locked(lk_p));

  lcd_timing_decoder #(.H_VALID(11'd8), .V_VALID(11'd4), .HS_POL(1'b0), .VS_POL(1'b0),
                       .LOCK_FRAMES(4'd2)) dut_n (
    .lcd_clk(clk), .sys_rst_n(rst_n), .lcd_hs(hs_n), .lcd_vs(vs_n), .lcd_de(de),
`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
    .err_clr(err_clr), .err_status(st_n),
`endif
    .pix_valid(pv_n), .pixel_xpos(xp_n), .pixel_ypos(yp_n), .frame_start(fs_n),
    .h_total_meas(ht_n), .v_total_meas(vt_n), .err_hact(eh_n), .err_vact(ev_n), .locked(lk_n));

  int n_assert = 0;
  int n_fail   = 0;

  // Frame description consumed by send_frame
  int de_len [LINES];
  int de_st;
  bit clr_line1;
  int rst_line, rst_c, rel_line;
  bit in_reset;

  // Frame-level reference model state
  bit first_vs_m, frame_short, exp_locked;
  int vs_seen, lines_since, line_starts, de_lines, prev_vtot, streak, exp_vtot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    first_vs_m = 0; frame_short = 0; exp_locked = 0;
    vs_seen = 0; lines_since = 0; line_starts = 0; de_lines = 0;
    prev_vtot = 0; streak = 0; exp_vtot = 0;
`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
    exp_status = 2'b00; prev_pulse = 2'b00;
`endif
  endtask

  task automatic check_zero();
    chk("rst_p_pv", 32'(pv_p), 0); chk("rst_n_pv", 32'(pv_n), 0);
    chk("rst_p_xpos", 32'(xp_p), 0); chk("rst_n_xpos", 32'(xp_n), 0);
    chk("rst_p_ypos", 32'(yp_p), 0); chk("rst_n_ypos", 32'(yp_n), 0);
    chk("rst_p_fs", 32'(fs_p), 0); chk("rst_n_fs", 32'(fs_n), 0);
    chk("rst_p_htot", 32'(ht_p), 0); chk("rst_n_htot", 32'(ht_n), 0);
    chk("rst_p_vtot", 32'(vt_p), 0); chk("rst_n_vtot", 32'(vt_n), 0);
    chk("rst_p_eh", 32'(eh_p), 0); chk("rst_n_eh", 32'(eh_n), 0);
    chk("rst_p_ev", 32'(ev_p), 0); chk("rst_n_ev", 32'(ev_n), 0);
    chk("rst_p_lock", 32'(lk_p), 0); chk("rst_n_lock", 32'(lk_n), 0);
`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
    chk("rst_p_status", 32'(st_p), 0); chk("rst_n_status", 32'(st_n), 0);
`endif
  endtask

  // Called just after the clock edge at which cycle (l, c) of the frame was presented.
  task automatic check_cycle(input int l, input int c);
    bit line_start, vs_e, de_fall_e, pix, e_hact, e_vact, clean;
    int k;
    line_start = (c == 0);
    vs_e       = line_start && (l == 0);
    pix        = (de_len[l] > 0) && (c >= de_st) && (c < de_st + de_len[l]);
    de_fall_e  = (de_len[l] > 0) && (c == de_st + de_len[l]);
    k          = c - de_st;
    e_hact = 0; e_vact = 0; clean = 0;
    if (de_fall_e) begin
      if (first_vs_m && de_len[l] != HV) begin
        e_hact = 1;
        frame_short = 1;
      end
      de_lines++;
    end
    if (vs_e) begin
      e_vact = first_vs_m && (de_lines != VV);
      clean  = first_vs_m && !frame_short && (de_lines == VV) &&
               (vs_seen < 2 || lines_since == prev_vtot);
      exp_vtot   = lines_since;
      prev_vtot  = lines_since;
      streak     = clean ? streak + 1 : 0;
      exp_locked = (streak >= LOCKN);
      vs_seen++;
      first_vs_m = 1; de_lines = 0; lines_since = 0; frame_short = 0;
    end
    if (line_start) begin
      if (line_starts >= 1) begin
        chk("p_htot", 32'(ht_p), 32'(LINE));
        chk("n_htot", 32'(ht_n), 32'(LINE));
      end
      line_starts++;
      lines_since++;
    end
    chk("p_pv", 32'(pv_p), 32'(pix)); chk("n_pv", 32'(pv_n), 32'(pix));
    if (pix) begin
      chk("p_xpos", 32'(xp_p), 32'(k)); chk("n_xpos", 32'(xp_n), 32'(k));
      chk("p_ypos", 32'(yp_p), 32'(de_lines)); chk("n_ypos", 32'(yp_n), 32'(de_lines));
    end
    chk("p_fs", 32'(fs_p), 32'(vs_e)); chk("n_fs", 32'(fs_n), 32'(vs_e));
    chk("p_err_hact", 32'(eh_p), 32'(e_hact)); chk("n_err_hact", 32'(eh_n), 32'(e_hact));
    chk("p_err_vact", 32'(ev_p), 32'(e_vact)); chk("n_err_vact", 32'(ev_n), 32'(e_vact));
    chk("p_locked", 32'(lk_p), 32'(exp_locked)); chk("n_locked", 32'(lk_n), 32'(exp_locked));
    chk("p_vtot", 32'(vt_p), 32'(exp_vtot)); chk("n_vtot", 32'(vt_n), 32'(exp_vtot));
`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
    exp_status = (exp_status & ~{err_clr, err_clr}) | prev_pulse;
    prev_pulse = {e_vact, e_hact};
    chk("p_status", 32'(st_p), 32'(exp_status)); chk("n_status", 32'(st_n), 32'(exp_status));
`endif
  endtask

  task automatic setup_frame(input int drop_line, input int short_line, input int short_len);
    for (int l = 0; l < LINES; l++) de_len[l] = (l >= 2 && l <= 5) ? HV : 0;
    if (drop_line >= 0) de_len[drop_line] = 0;
    if (short_line >= 0) de_len[short_line] = short_len;
    de_st = $urandom_range(2, 3);
  endtask

  task automatic send_frame();
    for (int l = 0; l < LINES; l++) begin
      for (int c = 0; c < LINE; c++) begin
        if (in_reset && l == rel_line && c == 0) begin
          rst_n = 1'b1;
          in_reset = 0;
        end
        hs = (c < 2);
        vs = (l == 0);
        de = (de_len[l] > 0) && (c >= de_st) && (c < de_st + de_len[l]);
`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
        err_clr = clr_line1 && (l == 1) && (c == 0);
`endif
        @(posedge clk);
        #1;
        if (!in_reset) check_cycle(l, c);
        if (l == rst_line && c == rst_c) begin
          #2 rst_n = 1'b0;
          #1 check_zero();
          model_reset();
          in_reset = 1;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
`ifdef LCD_TIMING_DEC_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    clr_line1 = 0; rst_line = -1; rst_c = -1; rel_line = -1; in_reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Clean stream: lock after the third VSYNC
    for (int f = 0; f < 4; f++) begin
      setup_frame(-1, -1, 0);
      send_frame();
    end

    // One short line while locked
    setup_frame(-1, int'($urandom_range(2, 5)), int'($urandom_range(4, 7)));
    send_frame();

    // Relock
    for (int f = 0; f < 2; f++) begin
      setup_frame(-1, -1, 0);
      send_frame();
    end

    // Clear sticky state, then drop one active line
    clr_line1 = 1;
    setup_frame(-1, -1, 0);
    send_frame();
    clr_line1 = 0;
    setup_frame(int'($urandom_range(2, 5)), -1, 0);
    send_frame();
    setup_frame(-1, -1, 0);
    send_frame();

    // Clear sticky state, then asynchronous reset in the middle of an active line
    clr_line1 = 1;
    rst_line = 3; rst_c = 5; rel_line = 4;
    setup_frame(-1, -1, 0);
    send_frame();
    clr_line1 = 0;
    rst_line = -1; rst_c = -1; rel_line = -1;

    for (int f = 0; f < 4; f++) begin
      setup_frame(-1, -1, 0);
      send_frame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
